// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Start/busy/done handshake; results are held until the next accepted start.
module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    a_sh;
  logic [N-1:0]  q_sh;
  logic [N:0]    trial;
  logic [N:0]    a_new;
  logic [N-1:0]  q_new;

  // Shared shift/subtract/restore datapath
  always_comb begin
    a_sh  = {a_q[N-1:0], q_q[N-1]};
    q_sh  = {q_q[N-2:0], 1'b0};
    trial = a_sh - {1'b0, m_q};
    if (trial[N]) begin
      a_new = a_sh;
      q_new = q_sh;
    end else begin
      a_new = trial;
      q_new = q_sh | {{(N-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      RUN: begin
        a_d   = a_new;
        q_d   = q_new;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_new;
          rem_d   = a_new[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d   = '0;
          q_d   = dividend;
          m_d   = divisor;
          cnt_d = CW'(N);
          if (divisor == '0) begin
            // Zero divisor skips the iteration entirely
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors = 0;
  int errors  = 0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result is plain arithmetic, delivered N cycles after acceptance
  logic [N-1:0] m_q = '0, m_r = '0, pq = '0, pr = '0;
  logic         m_dbz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int           left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0; m_r <= '0; m_dbz <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; left <= 0;
    end else if (m_busy) begin
      if (left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_q <= pq; m_r <= pr; m_dbz <= 1'b0; left <= 0;
      end else begin
        left <= left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (divisor == 0) begin
          m_done <= 1'b1; m_q <= '1; m_r <= dividend; m_dbz <= 1'b1;
        end else begin
          m_busy <= 1'b1; left <= N; pq <= dividend / divisor; pr <= dividend % divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  // Called at a negedge with the DUT able to accept; returns at the negedge where done is high.
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat = 0;
    while (!done && lat < N + 4) begin
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        dividend = N'(9);
        divisor  = N'(3);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic lit(input string name, input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez,
                     input int lat, input int elat);
    chk({name, "_q"}, 32'(quotient), 32'(eq));
    chk({name, "_r"}, 32'(remainder), 32'(er));
    chk({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
    chk({name, "_lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    int lat;
    logic [N-1:0] a, b;

    repeat (3) @(negedge clk);
    chk("reset_q", 32'(quotient), 32'd0);
    chk("reset_r", 32'(remainder), 32'd0);
    chk("reset_flags", 32'({busy, done, div_by_zero}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7, 1'b0, lat);   lit("d100_7", 8'd14, 8'd2, 1'b0, lat, N);
    repeat (3) @(negedge clk);
    chk("hold_q", 32'(quotient), 32'd14);
    do_div(8'd255, 8'd1, 1'b0, lat);   lit("d255_1", 8'd255, 8'd0, 1'b0, lat, N);
    do_div(8'd5, 8'd9, 1'b0, lat);     lit("d5_9", 8'd0, 8'd5, 1'b0, lat, N);
    do_div(8'd200, 8'd200, 1'b0, lat); lit("d200_200", 8'd1, 8'd0, 1'b0, lat, N);
    @(negedge clk);
    do_div(8'd42, 8'd0, 1'b0, lat);    lit("d42_0", 8'd255, 8'd42, 1'b1, lat, 0);
    @(negedge clk);
    do_div(8'd100, 8'd7, 1'b1, lat);   lit("noisy100_7", 8'd14, 8'd2, 1'b0, lat, N);
    do_div(8'd9, 8'd3, 1'b0, lat);     lit("b2b9_3", 8'd3, 8'd0, 1'b0, lat, N);
    @(negedge clk);

    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", 32'(quotient), 32'd0);
    chk("async_r", 32'(remainder), 32'd0);
    chk("async_flags", 32'({busy, done, div_by_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_div(8'd100, 8'd7, 1'b0, lat);   lit("post_rst", 8'd14, 8'd2, 1'b0, lat, N);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0: begin a = N'($urandom); b = '0; end
        1: begin b = N'($urandom_range(1, 255)); a = N'($urandom_range(0, int'(b) - 1)); end
        default: begin a = N'($urandom); b = N'($urandom_range(1, 255)); end
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_div(a, b, 1'($urandom_range(0, 1)), lat);
      if (b == 0) begin
        lit("rnd_dbz", '1, a, 1'b1, lat, 0);
      end else begin
        chk("rnd_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk("rnd_rem_lt", 32'(remainder < b), 32'd1);
        chk("rnd_lat", 32'(lat), 32'(N));
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
